cons_inject_sched: RTL and testbench
====================================

Name: cons_inject_sched

Overview:
- Synthesizable sequencer that injects one buffered command line into the console input FIFO, byte by byte.
- A loader (host bridge or test harness) streams up to DEPTH bytes in.
- Emission is held off until the boot window has passed (w_mtime >= min_time).
- Each byte is then written with a one-cycle we pulse, paced by the console's r_consf_en handshake and an inter-character gap.

Parameters:
- DEPTH, 16, line buffer entries (power of two, >=2).
- GAP_CYCLES, 64, idle cycles after each acknowledged byte (0 allowed).
- ACK_TIMEOUT, 1024, max cycles to wait for r_consf_en==1 after a write.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- w_mtime  in  64  current machine timer.
- min_time  in  64  boot threshold; unsigned compare.
- ld_valid  in  1  loader byte valid.
- ld_data  in  8  loader byte.
- ld_last  in  1  byte is last of line.
- ld_ready  out  1  loader byte accepted when ld_valid&&ld_ready.
- r_consf_en  in  1  console busy/ack: 0 = free to accept a write, 1 = byte taken.
- we  out  1  one-cycle write strobe to console FIFO.
- key  out  8  byte presented with we.
- busy  out  1  line loaded and not fully emitted.
- done  out  1  one-cycle pulse when line fully emitted.
- ovf  out  1  sticky: loader byte dropped because buffer full.
- to_err  out  1  sticky: ACK_TIMEOUT expired at least once.

Behaviour:
- Reset values: we=0, key=0, ld_ready=0, busy=0, done=0, ovf=0, to_err=0, boot_done=0, wr/rd pointers=0, count=0, state=IDLE.
- boot_done is sticky. It sets the cycle after w_mtime >= min_time is first sampled and clears only on rst.
- States:
  - IDLE: ld_ready=1. Go to LOAD on the first accepted byte, with that byte processed as in LOAD.
  - LOAD: ld_ready=1.
    - Accepted byte with ld_data==0: discarded, not stored.
    - Nonzero byte with count<DEPTH: stored at wr, wr/count increment.
    - Nonzero byte with count==DEPTH: dropped, ovf<=1.
    - Accepted byte with ld_last=1 ends the line; ld_ready drops the next cycle. Go to WAIT_FREE if count (after that byte) >0. Otherwise pulse done and return to IDLE (empty line).
  - WAIT_FREE: ld_ready=0, busy=1. Go to WRITE when boot_done && r_consf_en==0.
  - WRITE: exactly one cycle. we=1, key=buf[rd]; rd increments, count decrements. Go to WAIT_ACK.
  - WAIT_ACK: we=0; timer counts up.
    - r_consf_en==1 seen: go to GAP.
    - Timer reaches ACK_TIMEOUT-1 first: to_err<=1, go to GAP.
  - GAP: counts GAP_CYCLES (skipped if 0). Then go to WAIT_FREE if count>0. If count==0: done=1 for one cycle, busy=0, pointers reset, go to IDLE.
- Latency: with boot_done=1 and r_consf_en held 0, the first we asserts 2 cycles after the ld_last handshake (LOAD→WAIT_FREE→WRITE).
- Pacing: with r_consf_en toggling immediately, back-to-back byte period = 3+GAP_CYCLES cycles.
- key holds its last value when we=0. we is never high on two consecutive cycles.
- Pointers wrap modulo DEPTH (log2 width). count is log2(DEPTH)+1 bits.
- Load before boot is allowed; the line is held in WAIT_FREE until boot_done.
- r_consf_en==1 in WAIT_FREE simply stalls; no timeout applies there.
- rst mid-line (any state) discards the buffer and returns all outputs to reset values the next cycle. No partial done.
- ovf and to_err are cleared only by rst.

Decomposition:
- Shared package cons_pkg holds:
  - state enum (IDLE, LOAD, WAIT_FREE, WRITE, WAIT_ACK, GAP);
  - CONS_NUL=8'h00;
  - default DEPTH/GAP/timeout constants.
- One natural sub-module: cons_line_buf, a DEPTH x 8 synchronous-write, combinational-read buffer with wr/rd pointers, count, full and empty.

Test Plan:
- Boot gating: min_time=100, w_mtime counts from 0; load "ls\n" (6C,73,0A) with ld_last on 0A, r_consf_en=0 → no we before w_mtime reaches 100. Then 3 we pulses with key=6C,73,0A in order, done pulse after the last GAP, busy=0.
- Handshake pacing: GAP_CYCLES=4, boot done, r_consf_en asserted 1 cycle after each we and deasserted 1 cycle later → we spacing = 7 cycles, keys in order, to_err=0.
- NUL/empty: load bytes 00,41,00 (last on 00) → exactly one we with key=41. Then load a single 00 with last → done pulses with zero we, state back to IDLE.
- Overflow: DEPTH=16, load 18 nonzero bytes 0x30..0x41 with last on 0x41 → ovf=1, exactly 16 we pulses with keys 0x30..0x3F.
- Ack timeout: ACK_TIMEOUT=8, r_consf_en stuck 0, 2-byte line → to_err=1, both bytes still written, each we separated by 8+GAP+1 cycles, then done.
- Reset mid-operation: assert rst for 1 cycle in WAIT_ACK after byte 1 of 4 → we=0, busy=0, ovf=0, no done, no further we. A fresh 1-byte line afterwards emits normally.

Source files
------------

// File: rtl/cons_pkg.sv
// Shared types and constants for the console line injector.
package cons_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    WAIT_FREE = 3'd2,
    WRITE     = 3'd3,
    WAIT_ACK  = 3'd4,
    GAP       = 3'd5
  } cons_state_e;

  // Loader bytes equal to this value are discarded rather than buffered.
  localparam logic [7:0] CONS_NUL = 8'h00;

  // Default sizing and pacing.
  localparam int CONS_DEPTH_DEF       = 16;
  localparam int CONS_GAP_DEF         = 64;
  localparam int CONS_ACK_TIMEOUT_DEF = 1024;

endpackage

// File: rtl/cons_line_buf.sv
// DEPTH x 8 line buffer: synchronous write, combinational read at the read pointer.
module cons_line_buf #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          wr_ok;
  logic          rd_ok;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_q];

  // Pointer and occupancy update; writes to a full buffer and reads of an empty one are ignored.
  always_comb begin
    wr_ok   = wr_en && !full;
    rd_ok   = rd_en && !empty;
    wr_d    = wr_ok ? wr_q + AW'(1) : wr_q;
    rd_d    = rd_ok ? rd_q + AW'(1) : rd_q;
    count_d = count_q;
    if (wr_ok && !rd_ok) begin
      count_d = count_q + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // Pointer registers; clr rewinds the buffer for the next line.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array, no reset so it can map onto distributed/block memory.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/cons_inject_sched.sv
// Buffers one command line from a loader and injects it into the console FIFO
// byte by byte once the boot window has passed, paced by the console ack and a gap.
module cons_inject_sched
  import cons_pkg::*;
#(
  parameter int DEPTH       = CONS_DEPTH_DEF,
  parameter int GAP_CYCLES  = CONS_GAP_DEF,
  parameter int ACK_TIMEOUT = CONS_ACK_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] w_mtime,
  input  logic [63:0] min_time,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  input  logic        r_consf_en,
  output logic        we,
  output logic [7:0]  key,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic        to_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(ACK_TIMEOUT) + 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  cons_state_e   state_q, state_d;
  logic          boot_done_q, boot_done_d;
  logic          we_q, we_d;
  logic [7:0]    key_q, key_d;
  logic          ld_ready_q, ld_ready_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          to_err_q, to_err_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [GW-1:0] gap_q, gap_d;

  logic          buf_clr;
  logic          buf_wr_en;
  logic          buf_rd_en;
  logic [7:0]    buf_rd_data;
  logic [CW-1:0] buf_count;
  logic          buf_full;
  logic          buf_empty;

  logic          accept;
  logic          ack_done;
  logic          gap_done;
  logic [TW-1:0] timer_inc;

  cons_line_buf #(
    .DEPTH(DEPTH)
  ) u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr_en),
    .wr_data (ld_data),
    .rd_en   (buf_rd_en),
    .rd_data (buf_rd_data),
    .count   (buf_count),
    .full    (buf_full),
    .empty   (buf_empty)
  );

  // Next-state logic: load, wait for console free, one-cycle write, wait for ack, gap.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    gap_d     = gap_q;
    ovf_d     = ovf_q;
    to_err_d  = to_err_q;
    done_d    = 1'b0;
    buf_wr_en = 1'b0;
    buf_rd_en = 1'b0;
    buf_clr   = 1'b0;
    ack_done  = 1'b0;
    gap_done  = 1'b0;
    accept    = ld_valid && ld_ready_q;
    timer_inc = timer_q + TW'(1);

    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          state_d = LOAD;
          if (ld_data != CONS_NUL) begin
            if (buf_full) begin
              ovf_d = 1'b1;
            end else begin
              buf_wr_en = 1'b1;
            end
          end
          if (ld_last) begin
            if ((buf_count != '0) || buf_wr_en) begin
              state_d = WAIT_FREE;
            end else begin
              // Line had no storable bytes: finish immediately.
              done_d  = 1'b1;
              buf_clr = 1'b1;
              state_d = IDLE;
            end
          end
        end
      end
      WAIT_FREE: begin
        if (boot_done_q && !r_consf_en) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        buf_rd_en = 1'b1;
        timer_d   = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        timer_d = timer_inc;
        if (r_consf_en) begin
          ack_done = 1'b1;
        end else if (timer_inc == TW'(ACK_TIMEOUT - 1)) begin
          to_err_d = 1'b1;
          ack_done = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          gap_done = 1'b1;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A zero gap goes straight from the ack to the end-of-byte decision.
    if (ack_done) begin
      if (GAP_CYCLES > 0) begin
        state_d = GAP;
        gap_d   = '0;
      end else begin
        gap_done = 1'b1;
      end
    end

    if (gap_done) begin
      if (!buf_empty) begin
        state_d = WAIT_FREE;
      end else begin
        done_d  = 1'b1;
        buf_clr = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // Registered outputs derived from the next state so they align with the state register.
  always_comb begin
    boot_done_d = boot_done_q || (w_mtime >= min_time);
    we_d        = (state_d == WRITE);
    key_d       = (state_d == WRITE) ? buf_rd_data : key_q;
    ld_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    busy_d      = !((state_d == IDLE) || (state_d == LOAD));
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      boot_done_q <= 1'b0;
      we_q        <= 1'b0;
      key_q       <= '0;
      ld_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ovf_q       <= 1'b0;
      to_err_q    <= 1'b0;
      timer_q     <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      boot_done_q <= boot_done_d;
      we_q        <= we_d;
      key_q       <= key_d;
      ld_ready_q  <= ld_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ovf_q       <= ovf_d;
      to_err_q    <= to_err_d;
      timer_q     <= timer_d;
      gap_q       <= gap_d;
    end
  end

  assign we       = we_q;
  assign key      = key_q;
  assign ld_ready = ld_ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ovf      = ovf_q;
  assign to_err   = to_err_q;

endmodule

// File: tb/tb_cons_inject_sched.sv
// Directed bench for cons_inject_sched (DEPTH=16, GAP_CYCLES=4, ACK_TIMEOUT=8).
module tb_cons_inject_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] w_mtime = 64'd0;
  logic [63:0] min_time = 64'd0;
  logic        ld_valid = 1'b0;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_last = 1'b0;
  logic        ld_ready;
  logic        r_consf_en = 1'b0;
  logic        we;
  logic [7:0]  key;
  logic        busy;
  logic        done;
  logic        ovf;
  logic        to_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hs_cyc = 0;
  int done_cnt = 0;
  int we_consec = 0;
  bit prev_we = 1'b0;
  bit ack_on = 1'b0;
  bit mt_run = 1'b0;

  logic [7:0]  we_keys[$];
  int          we_cycs[$];
  logic [63:0] we_mts[$];

  cons_inject_sched #(
    .DEPTH(16),
    .GAP_CYCLES(4),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_mtime    (w_mtime),
    .min_time   (min_time),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .r_consf_en (r_consf_en),
    .we         (we),
    .key        (key),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf),
    .to_err     (to_err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Machine timer: free-runs from 0 while mt_run, otherwise held at 0.
  initial forever begin
    @(posedge clk);
    #1;
    w_mtime = mt_run ? w_mtime + 64'd1 : 64'd0;
  end

  // Console model: ack one cycle after a write, drop it one cycle later.
  initial forever begin
    @(negedge clk);
    if (ack_on && we) begin
      @(posedge clk); #1; r_consf_en = 1'b1;
      @(posedge clk); #1; r_consf_en = 1'b0;
    end
  end

  // Monitor: one line per emitted byte, plus done and back-to-back write tracking.
  initial forever begin
    @(negedge clk);
    if (we) begin
      we_keys.push_back(key);
      we_cycs.push_back(cyc);
      we_mts.push_back(w_mtime);
      $display("[%0d] we key=%02h mtime=%0d", cyc, key, w_mtime);
      if (prev_we) we_consec++;
    end
    if (done) begin
      done_cnt++;
      $display("[%0d] done", cyc);
    end
    prev_we = we;
  end

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    ld_valid = 1'b1;
    ld_data = d;
    ld_last = l;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = ld_ready;
      if (ok) hs_cyc = cyc;
      @(posedge clk); #1;
      n++;
    end
    ld_valid = 1'b0;
    ld_last = 1'b0;
    ld_data = 8'h00;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ld_handshake: byte %02h not accepted after %0d cycles, required accept", d, n);
    end else begin
      $display("[%0d] load byte=%02h last=%0b", hs_cyc, d, l);
    end
  endtask

  task automatic wait_done(input int base, input int max, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max && !ok; n++) begin
      @(posedge clk); #2;
      if (done_cnt > base) ok = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({we, key, ld_ready, busy, done, ovf, to_err} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: we=%0b key=%02h ld_ready=%0b busy=%0b done=%0b ovf=%0b to_err=%0b, required all 0",
               we, key, ld_ready, busy, done, ovf, to_err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ld_ready: ld_ready=%0b after release, required 1", ld_ready);
    end
  endtask

  task automatic test_boot_gating();
    int wb, db;
    bit ok;
    logic [7:0] exp_k [3];
    exp_k[0] = 8'h6C; exp_k[1] = 8'h73; exp_k[2] = 8'h0A;
    min_time = 64'd100;
    ack_on = 1'b1;
    mt_run = 1'b0;
    do_reset();
    mt_run = 1'b1;
    wb = we_keys.size();
    db = done_cnt;
    send_byte(8'h6C, 1'b0);
    send_byte(8'h73, 1'b0);
    send_byte(8'h0A, 1'b1);
    wait_done(db, 400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL boot_done_timeout: no done within bound, required done pulse");
    end
    checks++;
    if (we_keys.size() - wb != 3) begin
      errors++;
      $display("FAIL boot_we_count: got %0d we pulses, required 3", we_keys.size() - wb);
    end else begin
      checks++;
      if (we_mts[wb] !== 64'd102) begin
        errors++;
        $display("FAIL boot_first_we_time: first we at mtime=%0d, required 102", we_mts[wb]);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (we_keys[wb + i] !== exp_k[i]) begin
          errors++;
          $display("FAIL boot_key%0d: key=%02h, required %02h", i, we_keys[wb + i], exp_k[i]);
        end
      end
    end
    checks++;
    if (busy !== 1'b0 || done_cnt - db != 1) begin
      errors++;
      $display("FAIL boot_end: busy=%0b dones=%0d, required busy=0 dones=1", busy, done_cnt - db);
    end
    mt_run = 1'b0;
    min_time = 64'd0;
  endtask

  task automatic test_pacing();
    int wb, db;
    bit ok;
    ack_on = 1'b1;
    do_reset();
    wb = we_keys.size();
    db = done_cnt;
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b1);
    wait_done(db, 200, ok);
    checks++;
    if (!ok || we_keys.size() - wb != 3) begin
      errors++;
      $display("FAIL pace_count: done=%0b we pulses=%0d, required done=1 and 3", ok, we_keys.size() - wb);
    end else begin
      checks++;
      if (we_cycs[wb] - hs_cyc != 2) begin
        errors++;
        $display("FAIL pace_latency: first we %0d cycles after last handshake, required 2", we_cycs[wb] - hs_cyc);
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (we_keys[wb + i] !== 8'h41 + 8'(i)) begin
          errors++;
          $display("FAIL pace_key%0d: key=%02h, required %02h", i, we_keys[wb + i], 8'h41 + 8'(i));
        end
      end
      for (int i = 1; i < 3; i++) begin
        checks++;
        if (we_cycs[wb + i] - we_cycs[wb + i - 1] != 7) begin
          errors++;
          $display("FAIL pace_spacing%0d: spacing=%0d, required 7", i, we_cycs[wb + i] - we_cycs[wb + i - 1]);
        end
      end
    end
    checks++;
    if (to_err !== 1'b0) begin
      errors++;
      $display("FAIL pace_to_err: to_err=%0b, required 0", to_err);
    end
  endtask

  task automatic test_nul_empty();
    int wb, db;
    bit ok;
    ack_on = 1'b1;
    do_reset();
    wb = we_keys.size();
    db = done_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h41, 1'b0);
    send_byte(8'h00, 1'b1);
    wait_done(db, 100, ok);
    checks++;
    if (!ok || we_keys.size() - wb != 1) begin
      errors++;
      $display("FAIL nul_count: done=%0b we pulses=%0d, required done=1 and 1", ok, we_keys.size() - wb);
    end else begin
      checks++;
      if (we_keys[wb] !== 8'h41) begin
        errors++;
        $display("FAIL nul_key: key=%02h, required 41", we_keys[wb]);
      end
    end
    wb = we_keys.size();
    db = done_cnt;
    send_byte(8'h00, 1'b1);
    wait_done(db, 20, ok);
    checks++;
    if (!ok || we_keys.size() - wb != 0 || done_cnt - db != 1) begin
      errors++;
      $display("FAIL empty_line: done=%0b we pulses=%0d dones=%0d, required done=1 we=0 dones=1",
               ok, we_keys.size() - wb, done_cnt - db);
    end
    @(negedge clk);
    checks++;
    if (ld_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_idle: ld_ready=%0b busy=%0b, required 1 and 0", ld_ready, busy);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int wb, db, bad;
    bit ok;
    ack_on = 1'b1;
    do_reset();
    wb = we_keys.size();
    db = done_cnt;
    for (int i = 0; i < 18; i++) send_byte(8'h30 + 8'(i), i == 17);
    wait_done(db, 400, ok);
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag: ovf=%0b, required 1", ovf);
    end
    checks++;
    if (!ok || we_keys.size() - wb != 16) begin
      errors++;
      $display("FAIL ovf_count: done=%0b we pulses=%0d, required done=1 and 16", ok, we_keys.size() - wb);
    end else begin
      bad = 0;
      for (int i = 0; i < 16; i++) if (we_keys[wb + i] !== 8'h30 + 8'(i)) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL ovf_keys: %0d keys out of order (first=%02h last=%02h), required 30..3F",
                 bad, we_keys[wb], we_keys[wb + 15]);
      end
    end
  endtask

  // Runs straight after the overflow test so ovf is still set going in.
  task automatic test_reset_mid();
    int wb, db, n;
    bit seen, ok;
    ack_on = 1'b0;
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre_ovf: ovf=%0b, required 1", ovf);
    end
    wb = we_keys.size();
    db = done_cnt;
    send_byte(8'h61, 1'b0);
    send_byte(8'h62, 1'b0);
    send_byte(8'h63, 1'b0);
    send_byte(8'h64, 1'b1);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 50) begin
      @(negedge clk);
      seen = we;
      n++;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_first_we: no we within bound, required one");
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({we, busy, ovf, to_err, done, ld_ready} !== 6'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: we=%0b busy=%0b ovf=%0b to_err=%0b done=%0b ld_ready=%0b, required all 0",
               we, busy, ovf, to_err, done, ld_ready);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (we_keys.size() - wb != 1 || done_cnt - db != 0) begin
      errors++;
      $display("FAIL rstmid_quiet: we pulses=%0d dones=%0d, required 1 and 0", we_keys.size() - wb, done_cnt - db);
    end
    ack_on = 1'b1;
    db = done_cnt;
    send_byte(8'h5A, 1'b1);
    wait_done(db, 60, ok);
    checks++;
    if (!ok || we_keys.size() - wb != 2) begin
      errors++;
      $display("FAIL rstmid_fresh: done=%0b we pulses=%0d, required done=1 and 2", ok, we_keys.size() - wb);
    end else begin
      checks++;
      if (we_keys[wb + 1] !== 8'h5A) begin
        errors++;
        $display("FAIL rstmid_fresh_key: key=%02h, required 5A", we_keys[wb + 1]);
      end
    end
  endtask

  task automatic test_ack_timeout();
    int wb, db;
    bit ok;
    ack_on = 1'b0;
    do_reset();
    wb = we_keys.size();
    db = done_cnt;
    send_byte(8'h51, 1'b0);
    send_byte(8'h52, 1'b1);
    wait_done(db, 100, ok);
    checks++;
    if (to_err !== 1'b1) begin
      errors++;
      $display("FAIL to_flag: to_err=%0b, required 1", to_err);
    end
    checks++;
    if (!ok || we_keys.size() - wb != 2) begin
      errors++;
      $display("FAIL to_count: done=%0b we pulses=%0d, required done=1 and 2", ok, we_keys.size() - wb);
    end else begin
      checks++;
      if (we_keys[wb] !== 8'h51 || we_keys[wb + 1] !== 8'h52) begin
        errors++;
        $display("FAIL to_keys: keys=%02h,%02h, required 51,52", we_keys[wb], we_keys[wb + 1]);
      end
      checks++;
      if (we_cycs[wb + 1] - we_cycs[wb] != 13) begin
        errors++;
        $display("FAIL to_spacing: spacing=%0d, required 13", we_cycs[wb + 1] - we_cycs[wb]);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    checks++;
    if (we_consec != 0) begin
      errors++;
      $display("FAIL we_consecutive: %0d back-to-back we cycles, required 0", we_consec);
    end
    checks++;
    if (key !== 8'h52) begin
      errors++;
      $display("FAIL key_hold: key=%02h while idle, required 52", key);
    end
  endtask

  initial begin
    test_reset();
    test_boot_gating();
    test_pacing();
    test_nul_empty();
    test_overflow();
    test_reset_mid();
    test_ack_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
